// File: rtl/conv_phase_scheduler_if.sv
// Arbiter mode type and the scheduler's phase-control bundle.
// The master modport is the scheduler; the slave modport is the surrounding datapath.
package conv_phase_pkg;
    typedef enum logic {
        CONVOLUTION = 1'b0,
        POOLING     = 1'b1
    } arbiter_mode_t;
endpackage

interface conv_phase_scheduler_if #(
    parameter int TS_CNT_WIDTH = 16
);
    import conv_phase_pkg::*;

    logic                    timestep;
    logic                    event_fifo_empty;
    logic                    conv_busy;
    logic                    pool_done;
    arbiter_mode_t           mode;
    logic                    conv_enable;
    logic                    pool_start;
    logic                    timestep_done;
    logic [TS_CNT_WIDTH-1:0] timestep_count;
    logic                    busy;
    logic                    overrun;
    logic                    timeout;

    modport master (
        input  timestep, event_fifo_empty, conv_busy, pool_done,
        output mode, conv_enable, pool_start, timestep_done,
        output timestep_count, busy, overrun, timeout
    );

    modport slave (
        output timestep, event_fifo_empty, conv_busy, pool_done,
        input  mode, conv_enable, pool_start, timestep_done,
        input  timestep_count, busy, overrun, timeout
    );
endinterface

// File: rtl/conv_phase_scheduler.sv
// Per-timestep sequencer between the conv and pool phases; owns the BRAM arbiter mode
// and only flips it after the outgoing phase has been idle for DRAIN_CYCLES cycles.
//
// state        | meaning
// S_CONV       | conv module free-running, waiting for a pending timestep and empty FIFO
// S_DRAIN_CONV | conv gated, counting consecutive conv-idle cycles
// S_POOL_START | one-cycle pool launch, arbiter in POOLING
// S_POOL_WAIT  | waiting for pool_done or watchdog expiry
// S_DRAIN_POOL | fixed DRAIN_CYCLES settle before handing BRAM back to conv
// S_DONE       | one-cycle timestep completion pulse, count update
module conv_phase_scheduler
    import conv_phase_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter bit          POOL_ENABLE  = 1'b1,
    parameter int unsigned POOL_TIMEOUT = 65535,
    parameter int          TS_CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conv_phase_scheduler_if.master bus
);

    localparam int WD_W = (POOL_TIMEOUT > 1) ? $clog2(POOL_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_CONV,
        S_DRAIN_CONV,
        S_POOL_START,
        S_POOL_WAIT,
        S_DRAIN_POOL,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              drain_cnt;
    logic [WD_W-1:0]         wd_cnt;
    logic                    pending;
    logic                    drain_hit;
    logic                    wd_expire;
    logic                    pending_clr;

    arbiter_mode_t           mode_q;
    logic                    conv_enable_q;
    logic                    pool_start_q;
    logic                    timestep_done_q;
    logic [TS_CNT_WIDTH-1:0] count_q;
    logic                    busy_q;
    logic                    overrun_q;
    logic                    timeout_q;

    always_comb begin
        drain_hit   = (drain_cnt == 4'(DRAIN_CYCLES - 1));
        wd_expire   = (POOL_TIMEOUT != 0) && (wd_cnt == WD_W'(POOL_TIMEOUT - 1));
        state_nxt   = state;
        case (state)
            S_CONV:       if (pending && bus.event_fifo_empty) state_nxt = S_DRAIN_CONV;
            S_DRAIN_CONV: if (!bus.conv_busy && drain_hit)
                              state_nxt = POOL_ENABLE ? S_POOL_START : S_DONE;
            S_POOL_START: state_nxt = S_POOL_WAIT;
            S_POOL_WAIT:  if (bus.pool_done || wd_expire) state_nxt = S_DRAIN_POOL;
            S_DRAIN_POOL: if (drain_hit) state_nxt = S_DONE;
            S_DONE:       state_nxt = S_CONV;
            default:      state_nxt = S_CONV;
        endcase
        pending_clr = (state == S_CONV) && (state_nxt == S_DRAIN_CONV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_CONV;
            drain_cnt       <= '0;
            wd_cnt          <= '0;
            pending         <= 1'b0;
            mode_q          <= CONVOLUTION;
            conv_enable_q   <= 1'b1;
            pool_start_q    <= 1'b0;
            timestep_done_q <= 1'b0;
            count_q         <= '0;
            busy_q          <= 1'b0;
            overrun_q       <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state <= state_nxt;

            // Idle counter restarts on any conv activity; drain counter in DRAIN_POOL is unconditional.
            if (state_nxt != state)
                drain_cnt <= '0;
            else if (state == S_DRAIN_CONV)
                drain_cnt <= bus.conv_busy ? 4'd0 : drain_cnt + 4'd1;
            else if (state == S_DRAIN_POOL)
                drain_cnt <= drain_cnt + 4'd1;
            else
                drain_cnt <= '0;

            if (state == S_POOL_WAIT && state_nxt == S_POOL_WAIT)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;

            // A pulse coinciding with the clear is a fresh timestep, not an overrun.
            pending <= bus.timestep | (pending & ~pending_clr);
            if (bus.timestep && pending && !pending_clr)
                overrun_q <= 1'b1;

            if (state == S_POOL_WAIT && !bus.pool_done && wd_expire)
                timeout_q <= 1'b1;

            if (state == S_DONE)
                count_q <= count_q + 1'b1;

            mode_q          <= (state_nxt == S_POOL_START || state_nxt == S_POOL_WAIT ||
                                state_nxt == S_DRAIN_POOL) ? POOLING : CONVOLUTION;
            conv_enable_q   <= (state_nxt == S_CONV);
            pool_start_q    <= (state_nxt == S_POOL_START);
            timestep_done_q <= (state_nxt == S_DONE);
            busy_q          <= (state_nxt != S_CONV);
        end
    end

    assign bus.mode           = mode_q;
    assign bus.conv_enable    = conv_enable_q;
    assign bus.pool_start     = pool_start_q;
    assign bus.timestep_done  = timestep_done_q;
    assign bus.timestep_count = count_q;
    assign bus.busy           = busy_q;
    assign bus.overrun        = overrun_q;
    assign bus.timeout        = timeout_q;

endmodule

// File: doc/conv_phase_scheduler.md
Name: conv_phase_scheduler

Overview:
- Sequences each timestep of the convolution layer between the convolution phase and the pooling phase.
- Drives the feature-map BRAM arbiter's mode select.
- Gates the conv module and launches and monitors the pool module.
- Guarantees that no BRAM access from one phase is still in flight when the arbiter mode flips to the other phase.

Parameters:
- DRAIN_CYCLES, 2: consecutive idle cycles required before a mode switch; must be ≥ BRAM read latency; legal 1..15.
- POOL_ENABLE, 1: when 0, the pooling phase is skipped entirely.
- POOL_TIMEOUT, 65535: maximum number of cycles spent in POOL_WAIT before the watchdog aborts; 0 disables the watchdog.
- TS_CNT_WIDTH, 16: width of the timestep counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- timestep_i  in  1  single-cycle pulse marking the end of a timestep
- event_fifo_empty_i  in  1  input event FIFO is empty
- conv_busy_i  in  1  conv module has an event or BRAM access in flight
- pool_done_i  in  1  single-cycle pulse: pooling pass complete
- mode_o  out  arbiter_mode_t  CONVOLUTION or POOLING; drives the arbiter mode
- conv_enable_o  out  1  conv module may pop events
- pool_start_o  out  1  single-cycle pool launch
- timestep_done_o  out  1  single-cycle pulse: timestep fully processed
- timestep_count_o  out  TS_CNT_WIDTH  number of completed timesteps; wraps
- busy_o  out  1  high in every state except CONV
- overrun_o  out  1  sticky: a timestep pulse arrived while one was already pending
- timeout_o  out  1  sticky: pool watchdog expired

Behaviour:
- Outputs are registered or a Moore decode of the state register. No combinational path from inputs to outputs.
- Reset values: state CONV, mode_o=CONVOLUTION, conv_enable_o=1, pool_start_o=0, timestep_done_o=0, timestep_count_o=0, busy_o=0, overrun_o=0, timeout_o=0, pending=0, counters=0.
- Reset asserted mid-operation returns to the reset state at once. No pool_start_o or timestep_done_o is emitted on exit from reset.
- pending flag:
  - Set on timestep_i in any state.
  - If timestep_i arrives while pending=1, set overrun_o. The extra pulse is dropped; pending stays 1.
  - Cleared on the transition CONV→DRAIN_CONV. If timestep_i arrives in that same cycle, pending stays 1 (set wins).
- State CONV: conv_enable_o=1, mode_o=CONVOLUTION. Go to DRAIN_CONV when pending=1 and event_fifo_empty_i=1.
- State DRAIN_CONV: conv_enable_o=0, mode_o=CONVOLUTION.
  - The idle counter increments each cycle conv_busy_i=0 and resets to 0 when conv_busy_i=1.
  - When the counter reaches DRAIN_CYCLES: go to POOL_START if POOL_ENABLE=1, otherwise to DONE.
- State POOL_START: one cycle; mode_o=POOLING, pool_start_o=1. Go to POOL_WAIT. pool_done_i is ignored in this cycle.
- State POOL_WAIT: mode_o=POOLING; the watchdog counter increments each cycle.
  - pool_done_i=1 → DRAIN_POOL.
  - Else if POOL_TIMEOUT≠0 and the watchdog reaches POOL_TIMEOUT → set timeout_o, go to DRAIN_POOL.
  - If pool_done_i and expiry occur in the same cycle, done wins: no timeout.
- State DRAIN_POOL: mode_o=POOLING. Exactly DRAIN_CYCLES cycles, then DONE.
- State DONE: one cycle; mode_o=CONVOLUTION, conv_enable_o=0, timestep_done_o=1. timestep_count_o increments, visible the next cycle; 2^TS_CNT_WIDTH−1 wraps to 0. Go to CONV.
- conv_enable_o is 0 in every state except CONV.
- Latency from timestep_i at cycle t (FIFO empty, conv idle, DRAIN_CYCLES=2): DRAIN_CONV entered at t+2, pool_start_o at t+4.
- Latency from pool_done_i at cycle u: timestep_done_o at u+3, back in CONV at u+4.
- Guarantee: mode_o changes only after ≥DRAIN_CYCLES cycles with no access from the outgoing phase.

Test Plan:
- Reset, then timestep_i at t=10, FIFO empty, conv idle, pool_done_i at t=20 → conv_enable_o falls at 12; pool_start_o and mode_o=POOLING at 14; timestep_done_o at 23; mode_o=CONVOLUTION at 23; timestep_count_o=1 at 24; conv_enable_o=1 at 24.
- timestep_i with FIFO non-empty for 5 cycles → remain in CONV with conv_enable_o=1 until the FIFO empties; then proceed as above.
- In DRAIN_CONV, conv_busy_i toggles 1,0,1,0,0 → pool_start_o only after the final two consecutive idle cycles.
- POOL_TIMEOUT=8, pool_done_i never asserted → timeout_o=1 after 8 POOL_WAIT cycles; timestep_done_o still pulses; count increments.
- Second timestep_i while pending=1 → overrun_o=1, exactly one extra timestep processed. One timestep_i during POOL_WAIT → no overrun; the next timestep starts immediately after DONE.
- POOL_ENABLE=0 → mode_o never POOLING, pool_start_o never asserted. Also: rst_n pulsed low during POOL_WAIT → all outputs at reset values.
